terrain_crater: RTL and testbench
=================================

// Module: terrain_crater
// PURPOSE
//  Explosion carve engine sitting on the terrain store's read/write ports.
//  On start it does a read-modify-write of every column inside a circle, (cx,cy,r).
//  For each column it clears all ground bits inside the circle and writes the column back.
//  Its outputs drive the terrain store's we/write_addr/terrain_in; its read input is the store's q.
// PARAMETERS
//  NCOLS    640  number of terrain columns; valid x range is 0..NCOLS-1
//  FLOOR    479  last terrain row; bits FLOOR+1..511 pass through unmodified
//  RMAX_W   6    radius width; r range is 0..63
// PORTS
//  clk           in   1    system clock
//  reset_n       in   1    synchronous, active-low reset
//  start         in   1    1-cycle request; sampled only in IDLE
//  center_x      in   10   crater column
//  center_y      in   10   crater row; 0 = top
//  radius        in   6    crater radius in pixels
//  read_addr     out  10   column address to the terrain store
//  terrain_q     in   512  store read data; valid 1 cycle after read_addr is sampled
//  we            out  1    write enable to the terrain store
//  write_addr    out  10   column address for the write
//  terrain_wr    out  512  modified column data
//  busy          out  1    high from the cycle after start is accepted until done
//  done          out  1    1-cycle pulse when the last write completes
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE; outputs we, busy, done, read_addr, write_addr, terrain_wr all 0.
//  Reset mid-operation: abort immediately. No further writes; columns already written stay written.
//  Bit convention: bit y=1 means ground at row y. Carving forces bits to 0 and never sets a bit.
//  FSM states: IDLE -> SETUP -> ISSUE -> SQRT -> WRITE -> (ISSUE | DONE) -> IDLE.
//   IDLE: on start, latch cx, cy, r; busy<=1.
//   SETUP: compute the column range in 12-bit signed arithmetic.
//    x0 = max(cx-r, 0); x1 = min(cx+r, NCOLS-1).
//    If x0 > x1 (cx is off-screen), go directly to DONE with no writes.
//   ISSUE: drive read_addr=x. Compute dx=|x-cx| and t=r*r-dx*dx (13-bit unsigned).
//    Set h=r.
//   SQRT: while h*h > t, do h<=h-1, one step per cycle.
//    Exit when h*h <= t, and never before terrain_q is valid (minimum 1 cycle).
//    h is the largest integer with h*h + dx*dx <= r*r.
//   WRITE: clear rows y in [max(cy-h,0), min(cy+h,FLOOR)]; all other bits copy terrain_q.
//    Assert we=1 for exactly 1 cycle, with write_addr=x.
//    If x==x1, go to DONE; otherwise x<=x+1 and go to ISSUE.
//   DONE: done=1 and busy=0 for 1 cycle, then IDLE.
//  Latency per column: 3 + (number of SQRT decrements) cycles. Columns are processed strictly ascending.
//  A write always precedes the next column's read, so no read-after-write hazard exists.
//  start while busy: ignored, not queued. start in the DONE cycle: ignored.
//  If cy-h is negative or cy+h > FLOOR, the row range is clamped.
//   If cy > FLOOR+r, the column is rewritten unchanged.
//  r=0: exactly one column (cx) is written, with only row cy cleared.
//  The block never issues we outside the WRITE state.
// CONFIGURATION
//  CRATER_BEDROCK_EN defined: row FLOOR is never cleared; the clamp is min(cy+h, FLOOR-1).
//   The player cannot dig through the bottom of the screen.
//  Not defined: row FLOOR is carved like any other row.
// TESTING
//  Flat terrain (rows 310..479=1); cx=100, cy=310, r=3:
//   writes go to cols 97..103 only;
//   col 100 has rows 310..313 = 0 and 314 = 1;
//   col 98 has rows 310..312 = 0;
//   col 97 has only row 310 = 0; done pulses once.
//  Edge clamp: cx=0, r=5 -> exactly 6 writes (cols 0..5). cx=639, r=5 -> cols 634..639.
//  Off-screen: cx=700, r=5 -> no we, done 2 cycles after start.
//  start again while busy with cx=200: ignored; no writes near col 200; a single done pulse.
//  reset_n=0 during the 3rd column -> we=0 and busy=0 next cycle;
//   the first 2 columns are modified and the remaining columns are unchanged.
//  cx=50, cy=479, r=2:
//   with CRATER_BEDROCK_EN, row 479 of col 50 stays 1;
//   without it, row 479 becomes 0; bits 480..511 are unchanged in both cases.

Source files
------------

// File: rtl/terrain_crater_if.sv
// Bundle of the crater request/status signals and the terrain-store port pair.
// The slave modport belongs to the carve engine; the master side is the requester plus store.
interface terrain_crater_if #(
    parameter int RMAX_W = 6
);
    logic              start;
    logic [9:0]        center_x;
    logic [9:0]        center_y;
    logic [RMAX_W-1:0] radius;
    logic              busy;
    logic              done;
    logic [9:0]        read_addr;
    logic [511:0]      terrain_q;
    logic              we;
    logic [9:0]        write_addr;
    logic [511:0]      terrain_wr;

    modport master (
        output start, center_x, center_y, radius, terrain_q,
        input  busy, done, read_addr, we, write_addr, terrain_wr
    );

    modport slave (
        input  start, center_x, center_y, radius, terrain_q,
        output busy, done, read_addr, we, write_addr, terrain_wr
    );
endinterface

// File: rtl/terrain_crater.sv
// Crater carve engine: read-modify-write of every terrain column inside a circle.
// Build option: define CRATER_BEDROCK_EN to make the bottom terrain row uncarvable.
module terrain_crater #(
    parameter int NCOLS  = 640,
    parameter int FLOOR  = 479,
    parameter int RMAX_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    terrain_crater_if.slave bus
);
    localparam int T_W = 2 * RMAX_W + 1;
`ifdef CRATER_BEDROCK_EN
    // The bottom row is bedrock: the player can never dig through the screen floor.
    localparam int CLR_LIM = FLOOR - 1;
`else
    localparam int CLR_LIM = FLOOR;
`endif
    localparam logic signed [11:0] X_MAX = 12'(NCOLS - 1);
    localparam logic [RMAX_W-1:0]  H_ONE = RMAX_W'(1);
    localparam logic [9:0]         X_ONE = 10'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_SQRT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [9:0]        cx_reg;
    logic [9:0]        cy_reg;
    logic [RMAX_W-1:0] r_reg;
    logic [9:0]        x_reg;
    logic [9:0]        x1_reg;
    logic [T_W-1:0]    t_reg;
    logic [RMAX_W-1:0] h_reg;
    logic [9:0]        read_addr_reg;
    logic [9:0]        write_addr_reg;
    logic [511:0]      wr_data_reg;

    logic              we_next;
    logic              busy_next;
    logic              done_next;

    // Column range of the circle, clipped to the screen.
    logic signed [11:0] lo_x, hi_x;
    logic [9:0]         x0_c, x1_c;
    logic               range_empty;

    assign lo_x        = $signed({2'b00, cx_reg}) - $signed(12'(r_reg));
    assign hi_x        = $signed({2'b00, cx_reg}) + $signed(12'(r_reg));
    assign x0_c        = lo_x[11] ? 10'd0 : lo_x[9:0];
    assign x1_c        = (hi_x > X_MAX) ? X_MAX[9:0] : hi_x[9:0];
    assign range_empty = (x0_c > x1_c);

    // Remaining squared half-height budget for the current column.
    logic [9:0]     dx_c;
    logic [T_W-1:0] t_c;
    logic [T_W-1:0] h_sq;
    logic           sqrt_go;

    assign dx_c    = (x_reg >= cx_reg) ? (x_reg - cx_reg) : (cx_reg - x_reg);
    assign t_c     = T_W'(20'(r_reg) * 20'(r_reg) - 20'(dx_c) * 20'(dx_c));
    assign h_sq    = T_W'(h_reg) * T_W'(h_reg);
    assign sqrt_go = (h_sq > t_reg);

    // Row span carved in this column; negative lo simply never matches a row.
    logic signed [11:0] lo_y, hi_y;
    logic [511:0]       clear_mask;

    assign lo_y = $signed({2'b00, cy_reg}) - $signed(12'(h_reg));
    assign hi_y = $signed({2'b00, cy_reg}) + $signed(12'(h_reg));

    genvar gi;
    generate
        for (gi = 0; gi < 512; gi++) begin : g_row
            localparam logic signed [11:0] ROW = 12'(gi);
            if (gi <= CLR_LIM) begin : g_carve
                assign clear_mask[gi] = (ROW >= lo_y) && (ROW <= hi_y);
            end else begin : g_keep
                assign clear_mask[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        we_next    = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                busy_next  = 1'b1;
                state_next = range_empty ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                busy_next  = 1'b1;
                state_next = S_SQRT;
            end
            S_SQRT: begin
                busy_next = 1'b1;
                if (!sqrt_go) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                busy_next  = 1'b1;
                we_next    = 1'b1;
                state_next = (x_reg == x1_reg) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cx_reg         <= '0;
            cy_reg         <= '0;
            r_reg          <= '0;
            x_reg          <= '0;
            x1_reg         <= '0;
            t_reg          <= '0;
            h_reg          <= '0;
            read_addr_reg  <= '0;
            write_addr_reg <= '0;
            wr_data_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        cx_reg <= bus.center_x;
                        cy_reg <= bus.center_y;
                        r_reg  <= bus.radius;
                    end
                end
                S_SETUP: begin
                    if (!range_empty) begin
                        x_reg         <= x0_c;
                        x1_reg        <= x1_c;
                        read_addr_reg <= x0_c;
                    end
                end
                S_ISSUE: begin
                    t_reg <= t_c;
                    h_reg <= r_reg;
                end
                S_SQRT: begin
                    // The store keeps q stable while read_addr is held, so the
                    // final SQRT cycle can merge the carve straight into the data.
                    if (sqrt_go) begin
                        h_reg <= h_reg - H_ONE;
                    end else begin
                        write_addr_reg <= x_reg;
                        wr_data_reg    <= bus.terrain_q & ~clear_mask;
                    end
                end
                S_WRITE: begin
                    if (x_reg != x1_reg) begin
                        x_reg         <= x_reg + X_ONE;
                        read_addr_reg <= x_reg + X_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.we         = we_next;
    assign bus.busy       = busy_next;
    assign bus.done       = done_next;
    assign bus.read_addr  = read_addr_reg;
    assign bus.write_addr = write_addr_reg;
    assign bus.terrain_wr = wr_data_reg;
endmodule

// File: tb/tb_terrain_crater.sv
// Self-checking bench for terrain_crater: directed table, corner sequences and a
// randomized run against a pixel-level circle model of the terrain.
module tb_terrain_crater;
    localparam int NCOLS = 640;
`ifdef CRATER_BEDROCK_EN
    localparam int   LIM          = 478;
    localparam logic ROW479_AFTER = 1'b1;
`else
    localparam int   LIM          = 479;
    localparam logic ROW479_AFTER = 1'b0;
`endif
    localparam logic [31:0] DEEP = 32'hA5C3_5A3C;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    terrain_crater_if bus ();
    terrain_crater dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    logic [511:0] mem   [NCOLS];
    logic [511:0] model [NCOLS];
    int wlog[$];
    int done_cnt;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int cx;
        int cy;
        int r;
        int n;
        int first;
    } vec_t;
    vec_t vecs[9];

    // Terrain store: registered read, write on we.
    always @(posedge clk) begin
        bus.terrain_q <= (bus.read_addr < 10'(NCOLS)) ? mem[bus.read_addr] : '0;
        if (bus.we) begin
            wlog.push_back(int'(bus.write_addr));
            if (bus.write_addr < 10'(NCOLS)) mem[bus.write_addr] <= bus.terrain_wr;
        end
        if (bus.done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic init_flat();
        logic [511:0] col;
        col = '0;
        for (int y = 310; y <= 479; y++) col[y] = 1'b1;
        col[511:480] = DEEP;
        for (int x = 0; x < NCOLS; x++) begin
            mem[x]   = col;
            model[x] = col;
        end
    endtask

    task automatic init_random();
        logic [511:0] col;
        for (int x = 0; x < NCOLS; x++) begin
            for (int w = 0; w < 16; w++) col[w*32 +: 32] = $urandom;
            mem[x]   = col;
            model[x] = col;
        end
    endtask

    // A pixel is carved when it lies inside the disc and above the carve limit.
    task automatic model_crater(input int cx, input int cy, input int r, input int max_cols);
        int n;
        n = 0;
        for (int x = cx - r; x <= cx + r; x++) begin
            if (x >= 0 && x < NCOLS && n < max_cols) begin
                n++;
                for (int y = 0; y <= LIM; y++)
                    if ((x - cx) * (x - cx) + (y - cy) * (y - cy) <= r * r) model[x][y] = 1'b0;
            end
        end
    endtask

    task automatic mem_diff(output int nbad, output int first_bad);
        nbad = 0;
        first_bad = -1;
        for (int x = 0; x < NCOLS; x++) begin
            if (mem[x] !== model[x]) begin
                if (nbad == 0) first_bad = x;
                nbad++;
            end
        end
    endtask

    task automatic drive(input int cx, input int cy, input int r);
        bus.center_x = 10'(cx);
        bus.center_y = 10'(cy);
        bus.radius   = 6'(r);
        bus.start    = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < 20000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_done_seen"}, 64'(k < 20000), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic verify(input string tag, input int exp_n, input int exp_first);
        int bad, nbad, fcol;
        check({tag, "_writes"}, 64'(wlog.size()), 64'(exp_n));
        bad = 0;
        foreach (wlog[i]) if (wlog[i] != exp_first + i) bad++;
        check({tag, "_addr_order_bad"}, 64'(bad), 64'd0);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        mem_diff(nbad, fcol);
        if (nbad != 0) $display("  %s first differing column %0d", tag, fcol);
        check({tag, "_mem_bad_cols"}, 64'(nbad), 64'd0);
    endtask

    task automatic run_op(input string tag, input int cx, input int cy, input int r,
                          input int exp_n, input int exp_first);
        wlog.delete();
        done_cnt = 0;
        model_crater(cx, cy, r, 1000);
        @(negedge clk);
        drive(cx, cy, r);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tag);
        verify(tag, exp_n, exp_first);
        $display("op %s cx=%0d cy=%0d r=%0d writes=%0d", tag, cx, cy, r, wlog.size());
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nbad, fcol, cnt, cx, cy, r, lo, hi;
        bus.start = 1'b0;
        bus.center_x = '0;
        bus.center_y = '0;
        bus.radius = '0;
        done_cnt = 0;
        init_flat();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 64'(bus.we), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_read_addr", 64'(bus.read_addr), 64'd0);
        check("rst_write_addr", 64'(bus.write_addr), 64'd0);
        check("rst_terrain_wr_any", 64'(|bus.terrain_wr), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Flat terrain reference crater with pixel-level checks
        init_flat();
        run_op("flat", 100, 310, 3, 7, 97);
        check("c100_r310_313", 64'(mem[100][313:310]), 64'd0);
        check("c100_r314", 64'(mem[100][314]), 64'd1);
        check("c98_r310_312", 64'(mem[98][312:310]), 64'd0);
        check("c98_r313", 64'(mem[98][313]), 64'd1);
        check("c97_r310", 64'(mem[97][310]), 64'd0);
        check("c97_r311", 64'(mem[97][311]), 64'd1);
        check("c104_r310", 64'(mem[104][310]), 64'd1);

        // Floor row and pass-through bits
        init_flat();
        run_op("floor", 50, 479, 2, 5, 48);
        check("c50_r479", 64'(mem[50][479]), 64'(ROW479_AFTER));
        check("c50_r478", 64'(mem[50][478]), 64'd0);
        check("c50_deep", 64'(mem[50][511:480]), 64'(DEEP));

        // Directed table
        vecs[0] = '{cx: 0,    cy: 300, r: 5,  n: 6,   first: 0};
        vecs[1] = '{cx: 639,  cy: 300, r: 5,  n: 6,   first: 634};
        vecs[2] = '{cx: 700,  cy: 300, r: 5,  n: 0,   first: 0};
        vecs[3] = '{cx: 320,  cy: 400, r: 0,  n: 1,   first: 320};
        vecs[4] = '{cx: 500,  cy: 20,  r: 63, n: 127, first: 437};
        vecs[5] = '{cx: 200,  cy: 500, r: 10, n: 21,  first: 190};
        vecs[6] = '{cx: 5,    cy: 0,   r: 8,  n: 14,  first: 0};
        vecs[7] = '{cx: 700,  cy: 300, r: 63, n: 3,   first: 637};
        vecs[8] = '{cx: 1023, cy: 100, r: 63, n: 0,   first: 0};
        for (int i = 0; i < 9; i++) begin
            init_flat();
            run_op($sformatf("vec%0d", i), vecs[i].cx, vecs[i].cy, vecs[i].r, vecs[i].n, vecs[i].first);
        end

        // Off-screen: done two cycles after start; a start in the DONE cycle is ignored
        init_flat();
        wlog.delete();
        done_cnt = 0;
        @(negedge clk);
        drive(700, 300, 5);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("off_c1_done", 64'(bus.done), 64'd0);
        check("off_c1_busy", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        check("off_c2_done", 64'(bus.done), 64'd1);
        check("off_c2_busy", 64'(bus.busy), 64'd0);
        drive(300, 300, 2);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("done_start_busy", 64'(bus.busy), 64'd0);
        check("done_start_done", 64'(bus.done), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("off_writes", 64'(wlog.size()), 64'd0);
        check("off_done_pulses", 64'(done_cnt), 64'd1);
        $display("op offscreen_timing writes=%0d done_pulses=%0d", wlog.size(), done_cnt);

        // Start while busy is dropped
        init_flat();
        wlog.delete();
        done_cnt = 0;
        model_crater(100, 310, 10, 1000);
        @(negedge clk);
        drive(100, 310, 10);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        drive(200, 310, 10);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("busy_start");
        verify("busy_start", 21, 90);
        cnt = 0;
        foreach (wlog[i]) if (wlog[i] >= 190 && wlog[i] <= 210) cnt++;
        check("busy_start_near200", 64'(cnt), 64'd0);
        $display("op busy_start writes=%0d", wlog.size());

        // Reset during the third column
        init_flat();
        wlog.delete();
        done_cnt = 0;
        model_crater(300, 310, 5, 2);
        @(negedge clk);
        drive(300, 310, 5);
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (wlog.size() < 2 && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("rstmid_two_writes", 64'(wlog.size()), 64'd2);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_we", 64'(bus.we), 64'd0);
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("rstmid_writes_final", 64'(wlog.size()), 64'd2);
        check("rstmid_done_pulses", 64'(done_cnt), 64'd0);
        mem_diff(nbad, fcol);
        check("rstmid_mem_bad_cols", 64'(nbad), 64'd0);
        $display("op reset_mid writes=%0d", wlog.size());

        // Randomized craters on random terrain
        init_random();
        for (int i = 0; i < 15; i++) begin
            cx = $urandom_range(0, 719);
            cy = $urandom_range(0, 560);
            r  = $urandom_range(0, 63);
            lo = (cx - r < 0) ? 0 : cx - r;
            hi = (cx + r > NCOLS - 1) ? NCOLS - 1 : cx + r;
            run_op($sformatf("rnd%0d", i), cx, cy, r, (hi >= lo) ? hi - lo + 1 : 0, lo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
